hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the fixed two-operand forwarding/flush unit of the 5-stage RISC-V core.
- Keeps its own shadow scoreboard of in-flight destinations (E, M, W) instead of relying on pipeline-register taps.
- Generates, with a fixed priority:
  - operand forwarding selects for NUM_SRC sources;
  - load-use stalls;
  - serialising drains for CSR/fence instructions;
  - redirect flushes.
- Sits beside decode/execute; drives stall/flush of the fetch, decode and execute pipeline registers.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 30 +++
 rtl/hazard_scoreboard_unit_fwd_match.sv | 32 +++
 rtl/hazard_scoreboard_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_pkg: shared definitions for the hazard scoreboard unit.
//   - forwarding select encodings (FWD_REG / FWD_MEM / FWD_WB)
//   - shadow scoreboard control entry {valid, regwrite, is_load}
//   - serialise FSM state encoding (IDLE, DRAIN)
//   - eff_writer(): "this entry really writes a non-x0 register"
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Control half of a shadow entry. The destination index lives beside it
  // as a plain vector because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
  } shadow_ctl_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // x0 is hard-wired zero, so a write to it is never a real producer.
  function automatic logic eff_writer(input shadow_ctl_t ctl, input logic rd_nonzero);
    return ctl.valid && ctl.regwrite && rd_nonzero;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_fwd_match.sv
// hazard_fwd_match: forwarding select for one EX operand.
//   rs, rs_used   operand index held in the E shadow entry and its read flag
//   m_rd, m_ok    M destination; m_ok = effective writer that is not a load
//   w_rd, w_ok    W destination; w_ok = effective writer
//   fwd_sel       FWD_MEM if M matches, else FWD_WB if W matches, else FWD_REG
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  m_ok,
  input  logic [REG_ADDR_W-1:0] w_rd,
  input  logic                  w_ok,
  output logic [1:0]            fwd_sel
);

  logic m_hit;
  logic w_hit;

  always_comb begin
    m_hit = rs_used && m_ok && (rs == m_rd);
    w_hit = rs_used && w_ok && (rs == w_rd);
    // M is the younger producer, so it wins over W.
    if (m_hit)      fwd_sel = FWD_MEM;
    else if (w_hit) fwd_sel = FWD_WB;
    else            fwd_sel = FWD_REG;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: shadow scoreboard of in-flight destinations (E, M, W)
// producing forwarding selects, load-use stalls, serialising drains for
// CSR/fence instructions and redirect flushes.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   dec_valid ... dec_serialize   decode-stage instruction fields
//   ex_redirect             taken branch/jump in E
//   stall_f, stall_d        hold PC / F-D register
//   flush_d, flush_e        clear F-D register / bubble into D-E register
//   fwd_sel                 2 bits per EX operand (00 regfile, 01 M, 10 W)
//   drain_busy              serialise FSM is in DRAIN
//
// Optional: define HAZARD_PERF_CNT_EN to add saturating performance counters
//   perf_stall_cycles, perf_flush_events, perf_fwd_hits (PERF_W bits each).
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int PERF_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]            dec_rs_used,
  input  logic [REG_ADDR_W-1:0]         dec_rd,
  input  logic                          dec_regwrite,
  input  logic                          dec_is_load,
  input  logic                          dec_serialize,
  input  logic                          ex_redirect,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic                          drain_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]             perf_stall_cycles,
  output logic [PERF_W-1:0]             perf_flush_events,
  output logic [PERF_W-1:0]             perf_fwd_hits
`endif
);

  if (NUM_SRC < 1 || NUM_SRC > 3 || PERF_W < 1) begin : g_bad_cfg
    $error("hazard_scoreboard_unit: NUM_SRC must be 1..3 and PERF_W >= 1");
  end

  // Shadow entries: _p0 = E, _p1 = M, _p2 = W.
  shadow_ctl_t                   e_ctl_p0, m_ctl_p1, w_ctl_p2;
  logic [REG_ADDR_W-1:0]         e_rd_p0, m_rd_p1, w_rd_p2;
  logic [NUM_SRC*REG_ADDR_W-1:0] e_rs_p0;
  logic [NUM_SRC-1:0]            e_rs_used_p0;

  drain_state_e state_q, state_d;

  logic                 e_eff, m_fwd_ok, w_fwd_ok;
  logic                 rs_hits_e, load_use, pipe_not_empty, hold, issue;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 unused_w_load;

  // A load sitting in W has already produced its data, so W's load flag
  // carries no information for forwarding.
  assign unused_w_load = w_ctl_p2.is_load;

  assign e_eff          = eff_writer(e_ctl_p0, e_rd_p0 != '0);
  assign m_fwd_ok       = eff_writer(m_ctl_p1, m_rd_p1 != '0) && !m_ctl_p1.is_load;
  assign w_fwd_ok       = eff_writer(w_ctl_p2, w_rd_p2 != '0);
  assign pipe_not_empty = e_ctl_p0.valid || m_ctl_p1.valid || w_ctl_p2.valid;
  assign issue          = dec_valid && !stall_d && !flush_e;

  always_comb begin
    rs_hits_e = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (dec_rs_used[i] && (dec_rs[i*REG_ADDR_W +: REG_ADDR_W] == e_rd_p0))
        rs_hits_e = 1'b1;
    end
    load_use = dec_valid && e_eff && e_ctl_p0.is_load && rs_hits_e;
    hold     = load_use || (dec_serialize && dec_valid && pipe_not_empty);
  end

  // Forwarding selects come purely from registered state.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_fwd_match #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_match (
      .rs      (e_rs_p0[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used (e_rs_used_p0[i]),
      .m_rd    (m_rd_p1),
      .m_ok    (m_fwd_ok),
      .w_rd    (w_rd_p2),
      .w_ok    (w_fwd_ok),
      .fwd_sel (fwd_raw[i*2 +: 2])
    );
  end

  assign fwd_sel    = rst ? '0 : fwd_raw;
  assign drain_busy = !rst && (state_q == DRAIN);

  // Stall/flush priority and serialise FSM next state.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    state_d = state_q;

    if (!rst) begin
      if (ex_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hold) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (dec_valid && dec_serialize && pipe_not_empty) state_d = DRAIN;
      DRAIN:   if (!pipe_not_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ex_redirect) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- shadow advance: decode -> E (p0) -> M (p1) -> W (p2) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      e_ctl_p0     <= '0;
      m_ctl_p1     <= '0;
      w_ctl_p2     <= '0;
      e_rs_used_p0 <= '0;
    end else begin
      w_ctl_p2 <= m_ctl_p1;
      m_ctl_p1 <= e_ctl_p0;
      if (issue) begin
        e_ctl_p0     <= '{valid: 1'b1, regwrite: dec_regwrite, is_load: dec_is_load};
        e_rs_used_p0 <= dec_rs_used;
      end else begin
        // Bubble: also drop the read flags so a dead slot never forwards.
        e_ctl_p0     <= '0;
        e_rs_used_p0 <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    w_rd_p2 <= m_rd_p1;
    m_rd_p1 <= e_rd_p0;
    e_rd_p0 <= dec_rd;
    e_rs_p0 <= dec_rs;
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + PERF_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
      perf_fwd_hits     <= '0;
    end else begin
      perf_stall_cycles <= sat_inc(perf_stall_cycles, stall_d);
      perf_flush_events <= sat_inc(perf_flush_events, ex_redirect);
      perf_fwd_hits     <= sat_inc(perf_fwd_hits, |fwd_sel);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: a behavioural model of the
// three in-flight instruction slots is compared against the DUT every cycle,
// with directed scenarios carrying hand-computed expectations.
module tb_hazard_scoreboard_unit;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int PW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, dec_valid, dec_regwrite, dec_is_load, dec_serialize, ex_redirect;
  logic [NS*RW-1:0]  dec_rs;
  logic [NS-1:0]     dec_rs_used;
  logic [RW-1:0]     dec_rd;
  logic              stall_f, stall_d, flush_d, flush_e, drain_busy;
  logic [NS*2-1:0]   fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0]     perf_stall_cycles, perf_flush_events, perf_fwd_hits;
`endif

  hazard_scoreboard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs),
    .dec_rs_used(dec_rs_used), .dec_rd(dec_rd), .dec_regwrite(dec_regwrite),
    .dec_is_load(dec_is_load), .dec_serialize(dec_serialize),
    .ex_redirect(ex_redirect), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_sel(fwd_sel),
    .drain_busy(drain_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events),
    .perf_fwd_hits(perf_fwd_hits)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: slot 0 = instruction in EX, 1 = MEM, 2 = WB.
  bit p_v[3];
  int p_rd[3];
  bit p_rw[3];
  bit p_ld[3];
  int e_rs[NS];
  bit e_used[NS];
  bit m_drain;
  int mp_stall, mp_flush, mp_fwd;

  bit x_sf, x_sd, x_fd, x_fe, x_db, x_busy;
  logic [NS*2-1:0] x_fwd;

  function automatic bit writes(input int k, input int r);
    return p_v[k] && p_rw[k] && (p_rd[k] != 0) && (p_rd[k] == r);
  endfunction

  task automatic model_eval();
    bit lu, hold;
    int r;
    lu = 0;
    for (int i = 0; i < NS; i++) begin
      r = int'(dec_rs[i*RW +: RW]);
      if (dec_valid && dec_rs_used[i] && p_ld[0] && writes(0, r)) lu = 1;
    end
    x_busy = p_v[0] || p_v[1] || p_v[2];
    hold = lu || (dec_serialize && dec_valid && x_busy);
    {x_sf, x_sd, x_fd, x_fe, x_db} = '0;
    x_fwd = '0;
    if (!rst) begin
      if (ex_redirect) begin x_fd = 1; x_fe = 1; end
      else if (hold) begin x_sf = 1; x_sd = 1; x_fe = 1; end
      x_db = m_drain;
      for (int i = 0; i < NS; i++) begin
        if (e_used[i]) begin
          if (!p_ld[1] && writes(1, e_rs[i]))  x_fwd[i*2 +: 2] = 2'b01;
          else if (writes(2, e_rs[i]))         x_fwd[i*2 +: 2] = 2'b10;
        end
      end
    end
  endtask

  task automatic model_tick();
    bit iss;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin p_v[k] = 0; p_rw[k] = 0; p_ld[k] = 0; p_rd[k] = 0; end
      for (int i = 0; i < NS; i++) begin e_used[i] = 0; e_rs[i] = 0; end
      m_drain = 0; mp_stall = 0; mp_flush = 0; mp_fwd = 0;
    end else begin
      if (x_sd && mp_stall != -1) mp_stall++;
      if (ex_redirect && mp_flush != -1) mp_flush++;
      if (x_fwd != '0 && mp_fwd != -1) mp_fwd++;
      if (ex_redirect)  m_drain = 0;
      else if (m_drain) m_drain = x_busy;
      else              m_drain = dec_valid && dec_serialize && x_busy;
      for (int k = 2; k > 0; k--) begin
        p_v[k] = p_v[k-1]; p_rd[k] = p_rd[k-1]; p_rw[k] = p_rw[k-1]; p_ld[k] = p_ld[k-1];
      end
      iss = dec_valid && !x_sd && !x_fe;
      p_v[0]  = iss;
      p_rd[0] = int'(dec_rd);
      p_rw[0] = iss && dec_regwrite;
      p_ld[0] = iss && dec_is_load;
      for (int i = 0; i < NS; i++) begin
        e_rs[i]   = int'(dec_rs[i*RW +: RW]);
        e_used[i] = iss && dec_rs_used[i];
      end
    end
  endtask

  task automatic eval_cyc();
    @(negedge clk);
    model_eval();
    chk("stall_f", stall_f, x_sf);
    chk("stall_d", stall_d, x_sd);
    chk("flush_d", flush_d, x_fd);
    chk("flush_e", flush_e, x_fe);
    chk("drain_busy", drain_busy, x_db);
    chk("fwd_sel", fwd_sel, x_fwd);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cycles", perf_stall_cycles, mp_stall);
    chk("perf_flush_events", perf_flush_events, mp_flush);
    chk("perf_fwd_hits", perf_fwd_hits, mp_fwd);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic cyc();
    eval_cyc();
    tick();
  endtask

  task automatic drive(input bit v, input int rd, input bit rw, input bit ld,
                       input int rs0, input int rs1, input bit u0, input bit u1,
                       input bit ser, input bit red);
    dec_valid     = v;
    dec_rd        = RW'(rd);
    dec_regwrite  = rw;
    dec_is_load   = ld;
    dec_rs        = {RW'(rs1), RW'(rs0)};
    dec_rs_used   = {u1, u0};
    dec_serialize = ser;
    ex_redirect   = red;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain_pipe();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin p_v[k] = 0; p_rw[k] = 0; p_ld[k] = 0; p_rd[k] = 0; end
    for (int i = 0; i < NS; i++) begin e_used[i] = 0; e_rs[i] = 0; end
    m_drain = 0; mp_stall = 0; mp_flush = 0; mp_fwd = 0;

    // Reset with hazard-looking inputs: every output must stay low.
    rst = 1;
    drive(1, 5, 1, 1, 5, 5, 1, 1, 1, 1);
    cyc();
    eval_cyc();
    chk("reset_stall_d", stall_d, 0);
    chk("reset_flush_d", flush_d, 0);
    chk("reset_fwd_sel", fwd_sel, 0);
    chk("reset_drain_busy", drain_busy, 0);
    tick();
    rst = 0;
    drain_pipe();

    // Forward from M: ADD x5 ; SUB rs1=x5.
    drive(1, 5, 1, 0, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 6, 1, 0, 5, 3, 1, 1, 0, 0);
    eval_cyc(); chk("fwdM_no_stall", stall_d, 0); tick();
    idle();
    eval_cyc(); chk("fwdM_sel", fwd_sel, 4'b0001); tick();
    drain_pipe();

    // Forward from W: producer two slots ahead.
    drive(1, 6, 1, 0, 1, 2, 1, 1, 0, 0); cyc();
    idle(); cyc();
    drive(1, 9, 1, 0, 6, 0, 1, 0, 0, 0); cyc();
    idle();
    eval_cyc(); chk("fwdW_sel", fwd_sel, 4'b0010); tick();
    drain_pipe();

    // x5 written in both M and W: M wins.
    drive(1, 5, 1, 0, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 5, 1, 0, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 9, 1, 0, 5, 0, 1, 0, 0, 0); cyc();
    idle();
    eval_cyc(); chk("fwd_prio_sel", fwd_sel, 4'b0001); tick();
    drain_pipe();

    // Load-use: LW x7 ; ADD rs2=x7.
    drive(1, 7, 1, 1, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 8, 1, 0, 1, 7, 1, 1, 0, 0);
    eval_cyc();
    chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    chk("lu_flush_e", flush_e, 1);
    chk("lu_flush_d", flush_d, 0);
    tick();
    eval_cyc(); chk("lu_release", stall_d, 0); tick();
    idle();
    eval_cyc(); chk("lu_fwd", fwd_sel, 4'b1000); tick();
    drain_pipe();

    // x0 immunity: LW x0 ; ADD rs1=x0.
    drive(1, 0, 1, 1, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 8, 1, 0, 0, 3, 1, 1, 0, 0);
    eval_cyc(); chk("x0_no_stall", stall_d, 0); tick();
    idle();
    eval_cyc(); chk("x0_fwd", fwd_sel, 4'b0000); tick();
    drain_pipe();

    // Serialise with three writers in flight, then a reader of the CSR's rd.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      eval_cyc();
      chk($sformatf("ser_stall_%0d", k), stall_d, (k < 3) ? 1 : 0);
      chk($sformatf("ser_drain_%0d", k), drain_busy, (k > 0) ? 1 : 0);
      tick();
    end
    drive(1, 9, 1, 0, 4, 0, 1, 0, 0, 0);
    eval_cyc(); chk("ser_drain_done", drain_busy, 0); tick();
    idle();
    eval_cyc(); chk("ser_csr_issued", fwd_sel, 4'b0001); tick();
    drain_pipe();

    // Redirect during a load-use hold.
    drive(1, 7, 1, 1, 1, 2, 1, 1, 0, 0); cyc();
    drive(1, 8, 1, 0, 1, 7, 1, 1, 0, 1);
    eval_cyc();
    chk("rd_flush_d", flush_d, 1);
    chk("rd_flush_e", flush_e, 1);
    chk("rd_stall_f", stall_f, 0);
    chk("rd_stall_d", stall_d, 0);
    tick();
    idle();
    eval_cyc();
`ifdef HAZARD_PERF_CNT_EN
    chk("rd_perf_flush", perf_flush_events, 1);
`endif
    tick();
    drain_pipe();

    // Randomised traffic over a small register range to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0);
      cyc();
    end
    rst = 0;
    drain_pipe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
